// File: rtl/phys_reg_free_list.sv
// rtl/phys_reg_free_list.sv - physical register free-list FIFO with one branch checkpoint
module phys_reg_free_list #(
  parameter int NUM_PHYS = 64,
  parameter int NUM_ARCH = 32,
  parameter int TAG_W    = $clog2(NUM_PHYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_req,
  output logic                alloc_ready,
  output logic [TAG_W-1:0]    alloc_tag,
  input  logic                release_valid,
  input  logic [TAG_W-1:0]    release_tag,
  input  logic                ckpt_save,
  input  logic                ckpt_restore,
  output logic [TAG_W:0]      free_count,
  output logic [NUM_PHYS-1:0] free_bitmap,
  output logic                err_double_free
);

  localparam int PTR_W = TAG_W + 1;

  logic [TAG_W-1:0]    fifo [NUM_PHYS];
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [PTR_W-1:0]    ckpt_head;
  logic [PTR_W-1:0]    head_next;
  logic [PTR_W-1:0]    restore_dist;
  logic [TAG_W-1:0]    k_off [NUM_PHYS];
  logic [NUM_PHYS-1:0] bitmap;
  logic [NUM_PHYS-1:0] bitmap_next;
  logic [NUM_PHYS-1:0] restore_mask;
  logic                err;
  logic                grant;
  logic                rel_bad;
  logic                rel_ok;

  assign free_count      = tail - head;
  assign alloc_ready     = (free_count != '0) & ~ckpt_restore;
  assign alloc_tag       = fifo[head[TAG_W-1:0]];
  assign free_bitmap     = bitmap;
  assign err_double_free = err;

  assign grant     = alloc_req & alloc_ready;
  assign head_next = grant ? head + PTR_W'(1) : head;

  // A release is refused for tag 0, an already-free tag, or when every allocatable tag is free.
  assign rel_bad = release_valid & ((release_tag == '0) | bitmap[release_tag] |
                                    (free_count == PTR_W'(NUM_PHYS - 1)));
  assign rel_ok  = release_valid & ~rel_bad;

  // Entries in [ckpt_head, head) were handed out after the checkpoint; mark their tags free again.
  always_comb begin
    restore_mask = '0;
    restore_dist = head - ckpt_head;
    for (int k = 0; k < NUM_PHYS; k++) begin
      k_off[k] = TAG_W'(k) - ckpt_head[TAG_W-1:0];
      if ({1'b0, k_off[k]} < restore_dist) begin
        restore_mask[fifo[k]] = 1'b1;
      end
    end
  end

  always_comb begin
    bitmap_next = bitmap;
    if (grant) begin
      bitmap_next[alloc_tag] = 1'b0;
    end
    if (ckpt_restore) begin
      bitmap_next = bitmap_next | restore_mask;
    end
    if (rel_ok) begin
      bitmap_next[release_tag] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PHYS; i++) begin
        fifo[i] <= (i < NUM_PHYS - NUM_ARCH) ? TAG_W'(NUM_ARCH + i) : '0;
      end
      head      <= '0;
      tail      <= PTR_W'(NUM_PHYS - NUM_ARCH);
      ckpt_head <= '0;
      err       <= 1'b0;
      bitmap    <= {{(NUM_PHYS - NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};
    end else begin
      if (rel_ok) begin
        fifo[tail[TAG_W-1:0]] <= release_tag;
        tail                  <= tail + PTR_W'(1);
      end
      if (rel_bad) begin
        err <= 1'b1;
      end
      if (ckpt_restore) begin
        head <= ckpt_head;
      end else begin
        head <= head_next;
        if (ckpt_save) begin
          ckpt_head <= head_next;
        end
      end
      bitmap <= bitmap_next;
    end
  end

endmodule
